pc16_stack: RTL and testbench



---
 rtl/pc16_stack.sv | 118 +++++++++++
 tb/tb_pc16_stack.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pc16_stack.sv
// pc16_stack: 16-bit program counter with an integrated return-address stack.
// Optional build macro PC16_HALT_ON_ERR_EN freezes all commands except clr after a stack error.
module pc16_stack #(
    parameter int          WIDTH        = 16,
    parameter int          DEPTH        = 8,
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     load,
    input  logic                     inc,
    input  logic                     call,
    input  logic                     ret,
    input  logic [WIDTH-1:0]         in,
    output logic [WIDTH-1:0]         out,
    output logic [$clog2(DEPTH):0]   sp_count,
    output logic                     stack_empty,
    output logic                     stack_full,
    output logic                     stack_err
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    logic [WIDTH-1:0] r_pc;
    logic [SPW-1:0]   r_sp;
    logic             r_err;
    logic [WIDTH-1:0] r_stack [DEPTH];

    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [SPW-1:0]   w_sp_nxt;
    logic [SPW-1:0]   w_sp_m1;
    logic             w_err_nxt;
    logic             w_push;
    logic             w_empty;
    logic             w_full;
    logic             w_halt;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    // Next-sequential address, standing in for the upstream inc16 (wraps FFFF -> 0000).
    assign w_pc_inc = r_pc + 1'b1;

    assign w_empty  = (r_sp == '0);
    assign w_full   = (r_sp == SPW'(DEPTH));
    assign w_sp_m1  = r_sp - 1'b1;
    assign w_wr_idx = r_sp[AW-1:0];
    assign w_rd_idx = w_sp_m1[AW-1:0];

`ifdef PC16_HALT_ON_ERR_EN
    assign w_halt = r_err;
`else
    assign w_halt = 1'b0;
`endif

    // Priority: clr > ret > call > load > inc > hold.
    always_comb begin
        w_pc_nxt  = r_pc;
        w_sp_nxt  = r_sp;
        w_err_nxt = r_err;
        w_push    = 1'b0;
        if (clr) begin
            w_pc_nxt  = RESET_VECTOR;
            w_sp_nxt  = '0;
            w_err_nxt = 1'b0;
        end else if (!w_halt) begin
            if (ret) begin
                if (w_empty) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_pc_nxt = r_stack[w_rd_idx];
                    w_sp_nxt = w_sp_m1;
                end
            end else if (call) begin
                // An overflowing call still jumps; only the push is lost.
                w_pc_nxt = in;
                if (w_full) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_push   = 1'b1;
                    w_sp_nxt = r_sp + 1'b1;
                end
            end else if (load) begin
                w_pc_nxt = in;
            end else if (inc) begin
                w_pc_nxt = w_pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= RESET_VECTOR;
            r_sp  <= '0;
            r_err <= 1'b0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_sp  <= w_sp_nxt;
            r_err <= w_err_nxt;
        end
    end

    // Stack storage carries no reset; entries above the pointer are never read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_wr_idx] <= w_pc_inc;
        end
    end

    assign out         = r_pc;
    assign sp_count    = r_sp;
    assign stack_empty = w_empty;
    assign stack_full  = w_full;
    assign stack_err   = r_err;

endmodule

// File: tb/tb_pc16_stack.sv
// Testbench for pc16_stack: directed scenarios plus random commands against a queue-based model.
module tb_pc16_stack;

    localparam int DEPTH = 8;
    localparam int SPW   = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clr = 1'b0, load = 1'b0, inc = 1'b0, call = 1'b0, ret = 1'b0;
    logic [15:0]     d_in = 16'h0;
    logic [15:0]     d_out;
    logic [SPW-1:0]  sp_count;
    logic            stack_empty, stack_full, stack_err;

    int total = 0;
    int bad   = 0;

    // Reference model: PC value, return-address queue (back = top), sticky error.
    logic [15:0] m_pc = 16'h0;
    logic [15:0] m_stk[$];
    logic        m_err = 1'b0;

    pc16_stack #(.WIDTH(16), .DEPTH(DEPTH), .RESET_VECTOR(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .inc(inc), .call(call), .ret(ret),
        .in(d_in), .out(d_out), .sp_count(sp_count), .stack_empty(stack_empty),
        .stack_full(stack_full), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 16'h0000;
        m_stk.delete();
        m_err = 1'b0;
    endtask

    task automatic model_step(input bit c, input bit r, input bit ca, input bit l, input bit i,
                              input logic [15:0] d);
        bit halt;
        halt = 1'b0;
`ifdef PC16_HALT_ON_ERR_EN
        halt = m_err;
`endif
        if (c) begin
            model_reset();
        end else if (!halt) begin
            if (r) begin
                if (m_stk.size() == 0) m_err = 1'b1;
                else m_pc = m_stk.pop_back();
            end else if (ca) begin
                if (m_stk.size() == DEPTH) m_err = 1'b1;
                else m_stk.push_back(16'(m_pc + 16'd1));
                m_pc = d;
            end else if (l) begin
                m_pc = d;
            end else if (i) begin
                m_pc = 16'(m_pc + 16'd1);
            end
        end
    endtask

    // Drive one command for one clock, then advance the model; returns 1 ns after the edge.
    task automatic apply(input bit c, input bit r, input bit ca, input bit l, input bit i,
                         input logic [15:0] d);
        clr = c; ret = r; call = ca; load = l; inc = i; d_in = d;
        @(posedge clk);
        #1;
        model_step(c, r, ca, l, i, d);
        clr = 0; ret = 0; call = 0; load = 0; inc = 0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (d_out !== 16'h0000 || sp_count !== '0 || stack_empty !== 1'b1 ||
                     stack_full !== 1'b0 || stack_err !== 1'b0) begin
            bad++; $display("FAIL reset_state: out=%h sp=%0d e=%b f=%b err=%b, required out=0000 sp=0 e=1 f=0 err=0",
                            d_out, sp_count, stack_empty, stack_full, stack_err);
        end
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        apply(0, 0, 1, 0, 0, 16'h0123);
        total++; if (d_out !== 16'h0123) begin
            bad++; $display("FAIL pre_async: out=%h required=0123", d_out);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        total++; if (d_out !== 16'h0000 || sp_count !== '0 || stack_empty !== 1'b1 || stack_err !== 1'b0) begin
            bad++; $display("FAIL async_reset: out=%h sp=%0d e=%b err=%b, required out=0000 sp=0 e=1 err=0",
                            d_out, sp_count, stack_empty, stack_err);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_inc_load();
        logic [15:0] exp_v [5];
        exp_v[0] = 16'h0001; exp_v[1] = 16'h0002; exp_v[2] = 16'h0003;
        exp_v[3] = 16'hFFFF; exp_v[4] = 16'h0000;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) apply(0, 0, 0, 1, 0, 16'hFFFF);
            else        apply(0, 0, 0, 0, 1, 16'h5555);
            total++; if (d_out !== exp_v[k] || d_out !== m_pc) begin
                bad++; $display("FAIL inc_load[%0d]: out=%h required=%h", k, d_out, exp_v[k]);
            end
        end
    endtask

    task automatic test_call_ret();
        apply(0, 0, 0, 1, 0, 16'h0010);
        apply(0, 0, 1, 0, 0, 16'h0200);
        total++; if (d_out !== 16'h0200 || sp_count !== SPW'(1)) begin
            bad++; $display("FAIL call: out=%h sp=%0d required out=0200 sp=1", d_out, sp_count);
        end
        apply(0, 0, 0, 0, 1, 16'h0);
        apply(0, 0, 0, 0, 1, 16'h0);
        apply(0, 1, 0, 0, 0, 16'h0);
        total++; if (d_out !== 16'h0011 || stack_empty !== 1'b1 || stack_err !== 1'b0) begin
            bad++; $display("FAIL ret: out=%h empty=%b err=%b required out=0011 empty=1 err=0",
                            d_out, stack_empty, stack_err);
        end
    endtask

    task automatic test_overflow();
        apply(1, 0, 0, 0, 0, 16'h0);
        for (int k = 0; k <= DEPTH; k++) begin
            apply(0, 0, 1, 0, 0, 16'(16'h1000 + k));
            if (k == DEPTH - 1) begin
                total++; if (stack_full !== 1'b1 || stack_err !== 1'b0) begin
                    bad++; $display("FAIL full_flag: full=%b err=%b required full=1 err=0", stack_full, stack_err);
                end
            end
        end
        total++; if (d_out !== 16'h1008 || sp_count !== SPW'(8) || stack_err !== 1'b1) begin
            bad++; $display("FAIL overflow: out=%h sp=%0d err=%b required out=1008 sp=8 err=1",
                            d_out, sp_count, stack_err);
        end
`ifndef PC16_HALT_ON_ERR_EN
        for (int k = 0; k < DEPTH; k++) begin
            apply(0, 1, 0, 0, 0, 16'h0);
            total++; if (d_out !== m_pc || sp_count !== SPW'(m_stk.size())) begin
                bad++; $display("FAIL lifo[%0d]: out=%h sp=%0d required out=%h sp=%0d",
                                k, d_out, sp_count, m_pc, m_stk.size());
            end
        end
        total++; if (d_out !== 16'h0001 || stack_empty !== 1'b1) begin
            bad++; $display("FAIL lifo_last: out=%h empty=%b required out=0001 empty=1", d_out, stack_empty);
        end
`endif
    endtask

    task automatic test_underflow();
        apply(1, 0, 0, 0, 0, 16'h0);
        apply(0, 0, 0, 1, 0, 16'h0042);
        apply(0, 1, 0, 0, 0, 16'h0);
        total++; if (d_out !== 16'h0042 || stack_err !== 1'b1) begin
            bad++; $display("FAIL underflow: out=%h err=%b required out=0042 err=1", d_out, stack_err);
        end
        apply(0, 0, 0, 0, 1, 16'h0);
        apply(0, 0, 0, 1, 0, 16'h7777);
        total++; if (d_out !== m_pc || stack_err !== 1'b1) begin
            bad++; $display("FAIL post_err_cmds: out=%h err=%b required out=%h err=1", d_out, stack_err, m_pc);
        end
        apply(1, 0, 0, 0, 0, 16'h0);
        total++; if (d_out !== 16'h0000 || stack_err !== 1'b0 || stack_empty !== 1'b1) begin
            bad++; $display("FAIL clr: out=%h err=%b empty=%b required out=0000 err=0 empty=1",
                            d_out, stack_err, stack_empty);
        end
    endtask

    task automatic test_priority();
        apply(0, 0, 1, 0, 0, 16'h0555);
        apply(1, 1, 1, 1, 1, 16'h0ABC);
        total++; if (d_out !== 16'h0000 || sp_count !== '0) begin
            bad++; $display("FAIL prio_clr: out=%h sp=%0d required out=0000 sp=0", d_out, sp_count);
        end
        apply(0, 0, 1, 1, 1, 16'h0300);
        total++; if (d_out !== 16'h0300 || sp_count !== SPW'(1)) begin
            bad++; $display("FAIL prio_call: out=%h sp=%0d required out=0300 sp=1", d_out, sp_count);
        end
        apply(0, 1, 1, 1, 1, 16'h0999);
        total++; if (d_out !== 16'h0001 || sp_count !== '0) begin
            bad++; $display("FAIL prio_ret: out=%h sp=%0d required out=0001 sp=0", d_out, sp_count);
        end
    endtask

    task automatic test_random();
        bit c, r, ca, l, i;
        for (int n = 0; n < 400; n++) begin
            c  = ($urandom_range(0, 39) == 0);
            r  = ($urandom_range(0, 3) == 0);
            ca = ($urandom_range(0, 2) == 0);
            l  = ($urandom_range(0, 4) == 0);
            i  = ($urandom_range(0, 1) == 0);
            apply(c, r, ca, l, i, 16'($urandom));
            total++; if (d_out !== m_pc || sp_count !== SPW'(m_stk.size()) ||
                         stack_empty !== (m_stk.size() == 0) || stack_full !== (m_stk.size() == DEPTH) ||
                         stack_err !== m_err) begin
                bad++; $display("FAIL random[%0d]: out=%h sp=%0d e=%b f=%b err=%b required out=%h sp=%0d err=%b",
                                n, d_out, sp_count, stack_empty, stack_full, stack_err,
                                m_pc, m_stk.size(), m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_inc_load();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
